// File: rtl/simple_alu_pipelined.sv
// simple_alu_pipelined
//   Two-stage pipelined bit-manipulation / shift / compare / scan ALU with
//   valid/ready handshakes on both sides and a destination-tag passthrough.
//   Sustains one result per clock.
//
//   Stage 1 registers the operation: opcode, operands, tag, one-hot bit mask
//   and shift amount.
//   Stage 2 registers the result and its tag; these drive the outputs.
//
//   Optional build macro: SIMPLEALU_FLAGS_EN adds a registered ResultZero
//   output, set when the stage-2 result is all zeros.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. A producer holds valid and payload stable until it transfers.
//   InputReady may depend combinationally on ResultReady. ResultValid never
//   depends on ResultReady in the same cycle.
module simple_alu_pipelined #(
  parameter int DATABITWIDTH = 16,
  parameter int TAGBITWIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    async_rst,
  input  logic                    InputValid,
  output logic                    InputReady,
  input  logic [3:0]              MinorOpcode,
  input  logic [DATABITWIDTH-1:0] OperandAData,
  input  logic [DATABITWIDTH-1:0] OperandBData,
  input  logic [TAGBITWIDTH-1:0]  InputTag,
  output logic                    ResultValid,
  input  logic                    ResultReady,
  output logic [DATABITWIDTH-1:0] ResultOut,
  output logic [TAGBITWIDTH-1:0]  ResultTag
`ifdef SIMPLEALU_FLAGS_EN
  ,
  output logic                    ResultZero
`endif
);

  localparam int IDXW = $clog2(DATABITWIDTH);

  // Minor opcode encodings
  localparam logic [3:0] OpSet     = 4'h0;
  localparam logic [3:0] OpClear   = 4'h1;
  localparam logic [3:0] OpFlip    = 4'h2;
  localparam logic [3:0] OpSelect  = 4'h3;
  localparam logic [3:0] OpShr     = 4'h4;
  localparam logic [3:0] OpRor     = 4'h5;
  localparam logic [3:0] OpSar     = 4'h6;
  localparam logic [3:0] OpShl     = 4'h7;
  localparam logic [3:0] OpGeS     = 4'h8;
  localparam logic [3:0] OpLtS     = 4'h9;
  localparam logic [3:0] OpGeU     = 4'hA;
  localparam logic [3:0] OpLtU     = 4'hB;
  localparam logic [3:0] OpLowBit  = 4'hC;
  localparam logic [3:0] OpHighBit = 4'hD;
  localparam logic [3:0] OpRev     = 4'hE;
  localparam logic [3:0] OpNe      = 4'hF;

  // Pipeline control
  logic s1Valid;
  logic s2Valid;
  logic s1Advance;
  logic s2Advance;

  // Stage-1 payload
  logic [3:0]              s1Opcode;
  logic [DATABITWIDTH-1:0] s1A;
  logic [DATABITWIDTH-1:0] s1B;
  logic [TAGBITWIDTH-1:0]  s1Tag;
  logic [DATABITWIDTH-1:0] s1Mask;
  logic [IDXW-1:0]         s1Shamt;

  // Values precomputed from the issue-side operands
  logic [IDXW-1:0]         inIdx;
  logic [DATABITWIDTH-1:0] inMask;

  // Stage-2 combinational result
  logic [DATABITWIDTH-1:0] aluResult;
  logic [IDXW-1:0]         rorBack;
  logic                    cmpBit;
  logic [DATABITWIDTH-1:0] lowIdx;
  logic [DATABITWIDTH-1:0] highIdx;
  logic [DATABITWIDTH-1:0] revB;

  assign s2Advance   = !s2Valid || ResultReady;
  assign s1Advance   = s1Valid && s2Advance;
  assign InputReady  = !s1Valid || s2Advance;
  assign ResultValid = s2Valid;

  assign inIdx  = OperandBData[IDXW-1:0];
  assign inMask = {{(DATABITWIDTH-1){1'b0}}, 1'b1} << inIdx;

  // Stage 1: capture a new op whenever the stage is empty or draining
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      s1Valid  <= 1'b0;
      s1Opcode <= '0;
      s1A      <= '0;
      s1B      <= '0;
      s1Tag    <= '0;
      s1Mask   <= '0;
      s1Shamt  <= '0;
    end else if (InputReady) begin
      s1Valid <= InputValid;
      if (InputValid) begin
        s1Opcode <= MinorOpcode;
        s1A      <= OperandAData;
        s1B      <= OperandBData;
        s1Tag    <= InputTag;
        s1Mask   <= inMask;
        s1Shamt  <= inIdx;
      end
    end
  end

  // Lowest and highest set bit of B; an all-zero B yields DATABITWIDTH
  always_comb begin
    lowIdx  = DATABITWIDTH'(DATABITWIDTH);
    highIdx = DATABITWIDTH'(DATABITWIDTH);
    for (int i = DATABITWIDTH - 1; i >= 0; i--) begin
      if (s1B[i]) lowIdx = DATABITWIDTH'(i);
    end
    for (int i = 0; i < DATABITWIDTH; i++) begin
      if (s1B[i]) highIdx = DATABITWIDTH'(i);
    end
  end

  // Bit-reverse of B
  always_comb begin
    revB = '0;
    for (int i = 0; i < DATABITWIDTH; i++) begin
      revB[i] = s1B[DATABITWIDTH-1-i];
    end
  end

  // Compare ops produce a single bit that is zero-extended into the result
  always_comb begin
    cmpBit = 1'b0;
    case (s1Opcode)
      OpGeS:   cmpBit = $signed(s1A) >= $signed(s1B);
      OpLtS:   cmpBit = $signed(s1A) <  $signed(s1B);
      OpGeU:   cmpBit = s1A >= s1B;
      OpLtU:   cmpBit = s1A <  s1B;
      OpNe:    cmpBit = s1A != s1B;
      default: cmpBit = 1'b0;
    endcase
  end

  // Rotate uses the complementary left shift. A zero amount wraps to zero,
  // so A | A returns A unchanged.
  assign rorBack = IDXW'(0) - s1Shamt;

  // Result select from the stage-1 operation
  always_comb begin
    aluResult = '0;
    case (s1Opcode)
      OpSet:     aluResult = s1A | s1Mask;
      OpClear:   aluResult = s1A & ~s1Mask;
      OpFlip:    aluResult = s1A ^ s1Mask;
      OpSelect:  aluResult = {DATABITWIDTH{s1A[s1Shamt]}};
      OpShr:     aluResult = s1A >> s1Shamt;
      OpRor:     aluResult = (s1A >> s1Shamt) | (s1A << rorBack);
      OpSar:     aluResult = $unsigned($signed(s1A) >>> s1Shamt);
      OpShl:     aluResult = s1A << s1Shamt;
      OpGeS, OpLtS, OpGeU, OpLtU, OpNe:
                 aluResult = {{(DATABITWIDTH-1){1'b0}}, cmpBit};
      OpLowBit:  aluResult = lowIdx;
      OpHighBit: aluResult = highIdx;
      OpRev:     aluResult = revB;
      default:   aluResult = '0;
    endcase
  end

  // Stage 2: the output register advances unless writeback is stalling
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      s2Valid   <= 1'b0;
      ResultOut <= '0;
      ResultTag <= '0;
    end else if (s2Advance) begin
      s2Valid <= s1Valid;
      if (s1Advance) begin
        ResultOut <= aluResult;
        ResultTag <= s1Tag;
      end
    end
  end

`ifdef SIMPLEALU_FLAGS_EN
  // Zero flag registered alongside the result so that it holds during stalls
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      ResultZero <= 1'b0;
    end else if (s1Advance) begin
      ResultZero <= (aluResult == '0);
    end
  end
`endif

endmodule
